// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin sharing of one line-wide main memory between icache and dcache miss ports
module main_mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_read,
  input  logic [ADDR_WIDTH-1:0] ic_address,
  output logic [LINE_WIDTH-1:0] ic_read_data,
  output logic                  ic_busy_wait,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [ADDR_WIDTH-1:0] dc_address,
  input  logic [LINE_WIDTH-1:0] dc_write_data,
  output logic [LINE_WIDTH-1:0] dc_read_data,
  output logic                  dc_busy_wait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_write_data,
  input  logic [LINE_WIDTH-1:0] mem_read_data,
  input  logic                  mem_busy_wait
);
  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC, DONE} state_t;
  state_t state;
  logic lg_dc, gnt_dc, seen_busy;
  logic dc_req, ic_done, dc_done;
  assign dc_req       = dc_read | dc_write;
  assign ic_done      = (state == DONE) && !gnt_dc;
  assign dc_done      = (state == DONE) && gnt_dc;
  assign ic_busy_wait = ic_read & ~ic_done;
  assign dc_busy_wait = dc_req & ~dc_done;
  // a tie goes to whichever port was not served last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      lg_dc          <= 1'b0;
      gnt_dc         <= 1'b0;
      seen_busy      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      ic_read_data   <= '0;
      dc_read_data   <= '0;
    end else
      case (state)
        IDLE:
          if (dc_req && (!ic_read || !lg_dc)) begin
            state          <= GRANT_DC;
            gnt_dc         <= 1'b1;
            seen_busy      <= 1'b0;
            mem_read       <= !dc_write;
            mem_write      <= dc_write;
            mem_address    <= dc_address;
            mem_write_data <= dc_write_data;
          end else if (ic_read) begin
            state       <= GRANT_IC;
            gnt_dc      <= 1'b0;
            seen_busy   <= 1'b0;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= ic_address;
          end
        GRANT_IC, GRANT_DC:
          if (mem_busy_wait) seen_busy <= 1'b1;
          else if (seen_busy) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read && gnt_dc) dc_read_data <= mem_read_data;
            if (mem_read && !gnt_dc) ic_read_data <= mem_read_data;
          end
        DONE: begin
          lg_dc <= gnt_dc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed stimulus with a queue-based scoreboard and a busy-wait memory model
module tb_main_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] L10 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
  localparam logic [LW-1:0] L20 = 128'h00000020_00000020_00000020_00000020;
  localparam logic [LW-1:0] L30 = 128'h00000030_00000030_00000030_00000030;
  localparam logic [LW-1:0] L40 = 128'h00000040_00000040_00000040_00000040;
  localparam logic [LW-1:0] LAA = {16{8'hAA}};
  localparam logic [LW-1:0] L55 = {16{8'h55}};
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_read, dc_read, dc_write, mem_busy_wait;
  logic [AW-1:0] ic_address, dc_address, mem_address;
  logic [LW-1:0] ic_read_data, dc_read_data, dc_write_data, mem_write_data, mem_read_data;
  logic ic_busy_wait, dc_busy_wait, mem_read, mem_write;
  int checks = 0, errors = 0, mem_b = 1;
  always #5 clk = ~clk;

  main_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_read(ic_read), .ic_address(ic_address), .ic_read_data(ic_read_data), .ic_busy_wait(ic_busy_wait),
    .dc_read(dc_read), .dc_write(dc_write), .dc_address(dc_address), .dc_write_data(dc_write_data),
    .dc_read_data(dc_read_data), .dc_busy_wait(dc_busy_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_busy_wait(mem_busy_wait)
  );

  typedef struct {bit wr; logic [AW-1:0] addr; logic [LW-1:0] wd; int gap;} mexp_t;
  typedef struct {logic [LW-1:0] data; int lat;} cexp_t;
  mexp_t mq[$];
  cexp_t icq[$], dcq[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: a strobe starts one transaction, busy for mem_b cycles, then waits for the strobe to drop
  logic [LW-1:0] wr_arr [0:255];
  bit wr_vld [0:255];
  logic active, served, cur_wr;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_wd;
  int cnt;
  function automatic logic [LW-1:0] rd_line(input logic [AW-1:0] a);
    if (wr_vld[a[7:0]]) return wr_arr[a[7:0]];
    return (a == 28'h10) ? L10 : {4{4'h0, a}};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_busy_wait <= 1'b0; active <= 1'b0; served <= 1'b0; cnt <= 0; mem_read_data <= '0;
    end else if (!active && !served && (mem_read || mem_write)) begin
      active <= 1'b1; cnt <= mem_b; mem_busy_wait <= 1'b1;
      cur_wr <= mem_write; cur_addr <= mem_address; cur_wd <= mem_write_data;
    end else if (active) begin
      if (cnt <= 1) begin
        mem_busy_wait <= 1'b0; active <= 1'b0; served <= 1'b1;
        if (cur_wr) begin
          wr_arr[cur_addr[7:0]] = cur_wd;
          wr_vld[cur_addr[7:0]] = 1'b1;
        end else mem_read_data <= rd_line(cur_addr);
      end else cnt <= cnt - 1;
    end else if (!(mem_read || mem_write)) served <= 1'b0;

  // monitor: checks each new memory grant and each requester completion against the queues
  initial begin
    int ncyc, grant_cyc, last_done;
    bit prev_strobe;
    mexp_t m;
    cexp_t c;
    ncyc = 0; grant_cyc = 0; last_done = 0; prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if ((mem_read || mem_write) && !prev_strobe) begin
        if (mq.size() == 0) chk("unexpected_grant", {mem_write, mem_read, mem_address}, 0);
        else begin
          m = mq.pop_front();
          chk("grant_write", mem_write, m.wr);
          chk("grant_read", mem_read, !m.wr);
          chk("grant_addr", mem_address, m.addr);
          if (m.wr) chk("grant_wdata", mem_write_data, m.wd);
          if (m.gap >= 0) chk("grant_gap", ncyc - last_done, m.gap);
        end
        grant_cyc = ncyc;
      end
      prev_strobe = mem_read || mem_write;
      if (ic_read && !ic_busy_wait) begin
        if (icq.size() == 0) chk("unexpected_ic_done", 1, 0);
        else begin
          c = icq.pop_front();
          chk("ic_data", ic_read_data, c.data);
          chk("ic_latency", ncyc - grant_cyc, c.lat);
        end
        last_done = ncyc;
      end
      if ((dc_read || dc_write) && !dc_busy_wait) begin
        if (dcq.size() == 0) chk("unexpected_dc_done", 1, 0);
        else begin
          c = dcq.pop_front();
          chk("dc_data", dc_read_data, c.data);
          chk("dc_latency", ncyc - grant_cyc, c.lat);
        end
        last_done = ncyc;
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask
  task automatic exp_mem(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd, input int gap);
    mq.push_back('{wr, a, wd, gap});
  endtask
  task automatic exp_ic(input logic [LW-1:0] d, input int lat);
    icq.push_back('{d, lat});
  endtask
  task automatic exp_dc(input logic [LW-1:0] d, input int lat);
    dcq.push_back('{d, lat});
  endtask
  task automatic wait_done(input bit dc);
    int n;
    bit done;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      done = dc ? ((dc_read || dc_write) && !dc_busy_wait) : (ic_read && !ic_busy_wait);
    end while (!done && n < 200);
    chk(dc ? "dc_done_in_time" : "ic_done_in_time", done, 1);
    #1;
  endtask
  task automatic req_ic(input logic [AW-1:0] a, input bit keep);
    ic_address = a;
    ic_read = 1'b1;
    wait_done(1'b0);
    if (!keep) ic_read = 1'b0;
  endtask
  task automatic req_dc(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    dc_address = a;
    dc_write_data = wd;
    dc_read = rd;
    dc_write = wr;
    wait_done(1'b1);
    dc_read = 1'b0;
    dc_write = 1'b0;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    ic_read = 0; dc_read = 0; dc_write = 0;
    ic_address = '0; dc_address = '0; dc_write_data = '0;
    step();
    step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_ic_data", ic_read_data, 0);
    chk("rst_dc_data", dc_read_data, 0);
    chk("rst_ic_busy", ic_busy_wait, 0);
    chk("rst_dc_busy", dc_busy_wait, 0);
    rst_n = 1'b1;
    step();
    // single icache read, memory busy 5 cycles
    mem_b = 5;
    exp_mem(0, 28'h10, '0, -1);
    exp_ic(L10, 7);
    ic_address = 28'h10;
    ic_read = 1'b1;
    #1;
    chk("ic_busy_rises", ic_busy_wait, 1);
    chk("dc_busy_idle", dc_busy_wait, 0);
    req_ic(28'h10, 0);
    step();
    // dcache write-back leaves dc_read_data untouched
    mem_b = 3;
    exp_mem(1, 28'h3, LAA, -1);
    exp_dc('0, 5);
    req_dc(0, 1, 28'h3, LAA);
    step();
    // tie after reset: dcache first, then icache after a 2-cycle gap
    do_reset();
    mem_b = 2;
    exp_mem(0, 28'h40, '0, -1);
    exp_mem(0, 28'h20, '0, 2);
    exp_dc(L40, 4);
    exp_ic(L20, 4);
    fork
      req_dc(1, 0, 28'h40, '0);
      req_ic(28'h20, 0);
    join
    step();
    // both dcache strobes high means a write
    mem_b = 1;
    exp_mem(1, 28'h41, L55, -1);
    exp_dc(L40, 3);
    req_dc(1, 1, 28'h41, L55);
    step();
    // repeat tie after a dcache grant: icache first; dcache reads back the written line
    mem_b = 2;
    exp_mem(0, 28'h10, '0, -1);
    exp_mem(0, 28'h41, '0, 2);
    exp_ic(L10, 4);
    exp_dc(L55, 4);
    fork
      req_dc(1, 0, 28'h41, '0);
      req_ic(28'h10, 0);
    join
    step();
    // icache holds its request for three back-to-back lines
    mem_b = 1;
    exp_mem(0, 28'h20, '0, -1);
    exp_mem(0, 28'h30, '0, 2);
    exp_mem(0, 28'h40, '0, 2);
    exp_ic(L20, 3);
    exp_ic(L30, 3);
    exp_ic(L40, 3);
    req_ic(28'h20, 1);
    req_ic(28'h30, 1);
    req_ic(28'h40, 0);
    step();
    // reset mid-grant with memory busy, then the held dcache read is granted again
    mem_b = 8;
    exp_mem(0, 28'h30, '0, -1);
    dc_address = 28'h30;
    dc_read = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_busy_wait && n < 50);
    chk("mem_busy_seen", mem_busy_wait, 1);
    chk("mid_grant_read", mem_read, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_read", mem_read, 0);
    chk("async_rst_write", mem_write, 0);
    chk("async_rst_dc_busy", dc_busy_wait, 1);
    step();
    step();
    exp_mem(0, 28'h30, '0, -1);
    exp_dc(L30, 10);
    rst_n = 1'b1;
    wait_done(1'b1);
    dc_read = 1'b0;
    step();
    step();
    chk("mem_queue_empty", mq.size(), 0);
    chk("ic_queue_empty", icq.size(), 0);
    chk("dc_queue_empty", dcq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
